// File: rtl/bash_line_echo.sv
// bash_line_echo: reads one completed command line from bash into a local
// buffer, echoes it back one character at a time (optionally upper-cased),
// ends the echo with a 0 terminator, then signals completion. It waits for
// bash to acknowledge before it accepts the next line.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   out_newASCII_ready  bash has a completed line (held while the line is read)
//   out_lineLen[12:0]   line length in characters
//   lineOut[7:0]        current line character from bash
//   lineOut_nextASCII   one-cycle pulse: character consumed, bash advances
//   in_newASCII_ready   a response character is valid on lineIn
//   lineIn[7:0]         response character, 0 terminates the line
//   lineIn_nextASCII    bash consumed the current lineIn character
//   in_solved           one-cycle pulse: command finished
//   out_solved          bash acknowledged in_solved
//   busy                high whenever the block is not idle
module bash_line_echo #(
  parameter int BUFFER_LEN = 128,
  parameter bit UPCASE     = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        out_newASCII_ready,
  input  logic [12:0] out_lineLen,
  input  logic [7:0]  lineOut,
  output logic        lineOut_nextASCII,
  output logic        in_newASCII_ready,
  output logic [7:0]  lineIn,
  input  logic        lineIn_nextASCII,
  output logic        in_solved,
  input  logic        out_solved,
  output logic        busy
);

  localparam int          AW      = (BUFFER_LEN > 1) ? $clog2(BUFFER_LEN) : 1;
  localparam logic [12:0] BUF_MAX = 13'(BUFFER_LEN);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RECV    = 3'd1,
    EMIT    = 3'd2,
    SOLVE   = 3'd3,
    WAITACK = 3'd4
  } state_t;

  state_t      state_r;
  state_t      state_next_s;
  logic [12:0] len_r;
  logic [12:0] rx_cnt_r;
  logic [12:0] tx_idx_r;
  logic        next_pulse_r;
  logic        in_rdy_r;
  logic [7:0]  line_in_r;
  logic        in_solved_r;
  logic        busy_r;
  logic [7:0]  line_mem [BUFFER_LEN];

  logic [12:0] len_clip_s;
  logic [12:0] tx_idx_inc_s;
  logic        recv_done_s;
  logic        buf_we_s;
  logic        tx_last_s;

  // Character conversion applied on the echo path.
  function automatic logic [7:0] conv(input logic [7:0] c);
    logic [7:0] r;
    if (UPCASE && (c >= 8'h61) && (c <= 8'h7A)) begin
      r = c - 8'h20;
    end else begin
      r = c;
    end
    return r;
  endfunction

  assign lineOut_nextASCII = next_pulse_r;
  assign in_newASCII_ready = in_rdy_r;
  assign lineIn            = line_in_r;
  assign in_solved         = in_solved_r;
  assign busy              = busy_r;

  // Shared conditions for the receive and emit paths.
  always_comb begin
    len_clip_s   = (out_lineLen > BUF_MAX) ? BUF_MAX : out_lineLen;
    // Receive ends when the latched length is reached or bash withdraws the line.
    recv_done_s  = (rx_cnt_r == len_r) || !out_newASCII_ready;
    // A character is sampled only on the cycle after the previous pulse cleared,
    // so bash always has one full cycle to present the next character.
    buf_we_s     = (state_r == RECV) && !recv_done_s && !next_pulse_r && (rx_cnt_r < len_r);
    tx_idx_inc_s = tx_idx_r + 13'd1;
    tx_last_s    = (tx_idx_r >= len_r);
  end

  // Next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (out_newASCII_ready) state_next_s = RECV;
        else                    state_next_s = IDLE;
      end
      RECV: begin
        if (recv_done_s) state_next_s = (rx_cnt_r == 13'd0) ? SOLVE : EMIT;
        else             state_next_s = RECV;
      end
      EMIT: begin
        if (lineIn_nextASCII && tx_last_s) state_next_s = SOLVE;
        else                               state_next_s = EMIT;
      end
      SOLVE:   state_next_s = WAITACK;
      WAITACK: begin
        if (out_solved) state_next_s = IDLE;
        else            state_next_s = WAITACK;
      end
      default: state_next_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= IDLE;
    else        state_r <= state_next_s;
  end

  // Line storage; contents are meaningless after reset so it carries none.
  always_ff @(posedge clk) begin
    if (buf_we_s) line_mem[rx_cnt_r[AW-1:0]] <= lineOut;
  end

  // Counters and registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_r        <= 13'd0;
      rx_cnt_r     <= 13'd0;
      tx_idx_r     <= 13'd0;
      next_pulse_r <= 1'b0;
      in_rdy_r     <= 1'b0;
      line_in_r    <= 8'h00;
      in_solved_r  <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      next_pulse_r <= 1'b0;
      in_solved_r  <= 1'b0;
      busy_r       <= (state_next_s != IDLE);
      case (state_r)
        IDLE: begin
          if (out_newASCII_ready) begin
            len_r    <= len_clip_s;
            rx_cnt_r <= 13'd0;
          end
        end
        RECV: begin
          if (recv_done_s) begin
            // Early withdrawal shrinks the line to what was actually read.
            len_r    <= rx_cnt_r;
            tx_idx_r <= 13'd0;
            if (rx_cnt_r != 13'd0) begin
              in_rdy_r  <= 1'b1;
              line_in_r <= conv(line_mem[0]);
            end else begin
              in_solved_r <= 1'b1;
            end
          end else if (buf_we_s) begin
            rx_cnt_r     <= rx_cnt_r + 13'd1;
            next_pulse_r <= 1'b1;
          end
        end
        EMIT: begin
          if (lineIn_nextASCII) begin
            if (!tx_last_s) begin
              tx_idx_r  <= tx_idx_inc_s;
              line_in_r <= (tx_idx_inc_s < len_r) ? conv(line_mem[tx_idx_inc_s[AW-1:0]]) : 8'h00;
            end else begin
              // Terminator consumed.
              in_rdy_r    <= 1'b0;
              line_in_r   <= 8'h00;
              in_solved_r <= 1'b1;
            end
          end
        end
        SOLVE:   in_solved_r <= 1'b0;
        WAITACK: in_solved_r <= 1'b0;
        default: in_solved_r <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_bash_line_echo.sv
// Directed bench for bash_line_echo: a bash-side model drives lines in and
// acknowledges echoed characters; each scenario task checks its own results.
module tb_bash_line_echo;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        out_newASCII_ready = 1'b0;
  logic [12:0] out_lineLen = 13'd0;
  logic [7:0]  lineOut = 8'h00;
  logic        lineOut_nextASCII;
  logic        in_newASCII_ready;
  logic [7:0]  lineIn;
  logic        lineIn_nextASCII = 1'b0;
  logic        in_solved;
  logic        out_solved = 1'b0;
  logic        busy;

  int errors = 0;
  int checks = 0;

  logic [7:0] src [256];
  logic [7:0] echo_q [$];
  int pulse_cnt, gap_bad, stable_bad, solved_cnt, busy_bad, solved_lat, timeout;
  bit ever_rdy;

  bash_line_echo #(.BUFFER_LEN(128), .UPCASE(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .out_newASCII_ready(out_newASCII_ready), .out_lineLen(out_lineLen),
    .lineOut(lineOut), .lineOut_nextASCII(lineOut_nextASCII),
    .in_newASCII_ready(in_newASCII_ready), .lineIn(lineIn),
    .lineIn_nextASCII(lineIn_nextASCII), .in_solved(in_solved),
    .out_solved(out_solved), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic load_str(input string s);
    for (int i = 0; i < s.len(); i++) src[i] = s[i];
  endtask

  // Bash model: offers one line, acknowledges echo characters after ack_gap
  // idle cycles, acknowledges in_solved after ack_delay (>=2) cycles.
  task automatic drive_line(input int len_req, input int drop_after, input int ack_gap,
                            input int ack_delay, input bit intrude, input int abort_after);
    int rd_idx = 0, cyc = 0, last_pulse = -1, wait_cnt = 0, ack_wait = 0;
    bit acking = 0, done = 0;
    logic [7:0] cur_ch = 8'h00;
    pulse_cnt = 0; gap_bad = 0; stable_bad = 0; solved_cnt = 0; busy_bad = 0;
    solved_lat = -1; timeout = 0; ever_rdy = 0;
    echo_q.delete();
    out_lineLen = 13'(len_req);
    lineOut = (len_req > 0) ? src[0] : 8'h00;
    out_newASCII_ready = 1'b1;
    while (!done && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (lineOut_nextASCII) begin
        pulse_cnt++;
        if (last_pulse >= 0 && (cyc - last_pulse) != 2) gap_bad++;
        last_pulse = cyc;
        rd_idx++;
        lineOut = (rd_idx < len_req && rd_idx < 256) ? src[rd_idx] : 8'h00;
        if (drop_after >= 0 && pulse_cnt == drop_after) out_newASCII_ready = 1'b0;
      end
      if (in_newASCII_ready || in_solved) out_newASCII_ready = 1'b0;
      if (in_newASCII_ready) ever_rdy = 1'b1;
      if (lineIn_nextASCII) begin
        lineIn_nextASCII = 1'b0;
        wait_cnt = 0;
      end else if (in_newASCII_ready) begin
        if (wait_cnt == 0) cur_ch = lineIn;
        else if (lineIn !== cur_ch) stable_bad++;
        if (wait_cnt >= ack_gap) begin
          echo_q.push_back(lineIn);
          lineIn_nextASCII = 1'b1;
          if (abort_after >= 0 && echo_q.size() == abort_after) begin
            lineIn_nextASCII = 1'b0;
            done = 1'b1;
          end
        end else begin
          wait_cnt++;
        end
      end
      if (in_solved) begin
        solved_cnt++;
        if (!acking) begin acking = 1'b1; solved_lat = cyc; end
      end
      if (acking && !done) begin
        if (out_solved) begin
          out_solved = 1'b0;
          done = 1'b1;
        end else begin
          if (busy !== 1'b1) busy_bad++;
          if (intrude && ack_wait == 10) begin
            out_lineLen = 13'd3; lineOut = 8'h41; out_newASCII_ready = 1'b1;
          end
          if (intrude && ack_wait == 20) out_newASCII_ready = 1'b0;
          if (ack_wait >= ack_delay) out_solved = 1'b1;
          else ack_wait++;
        end
      end
    end
    if (!done) timeout = 1;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if (lineOut_nextASCII !== 1'b0) begin errors++; $display("FAIL reset_next: got %b want 0", lineOut_nextASCII); end
    checks++; if (in_newASCII_ready !== 1'b0) begin errors++; $display("FAIL reset_rdy: got %b want 0", in_newASCII_ready); end
    checks++; if (lineIn !== 8'h00) begin errors++; $display("FAIL reset_linein: got %h want 00", lineIn); end
    checks++; if (in_solved !== 1'b0) begin errors++; $display("FAIL reset_solved: got %b want 0", in_solved); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_ls();
    logic [7:0] want [3] = '{8'h4C, 8'h53, 8'h00};
    logic [7:0] got;
    load_str("ls");
    drive_line(2, -1, 0, 2, 1'b0, -1);
    checks++; if (timeout !== 0) begin errors++; $display("FAIL ls_timeout: got %0d want 0", timeout); end
    checks++; if (pulse_cnt !== 2) begin errors++; $display("FAIL ls_reads: got %0d want 2", pulse_cnt); end
    checks++; if (gap_bad !== 0) begin errors++; $display("FAIL ls_gap: got %0d bad gaps want 0", gap_bad); end
    checks++; if (echo_q.size() !== 3) begin errors++; $display("FAIL ls_len: got %0d want 3", echo_q.size()); end
    for (int i = 0; i < 3; i++) begin
      got = (i < echo_q.size()) ? echo_q[i] : 8'hxx;
      checks++; if (got !== want[i]) begin errors++; $display("FAIL ls_char%0d: got %h want %h", i, got, want[i]); end
    end
    checks++; if (solved_cnt !== 1) begin errors++; $display("FAIL ls_solved: got %0d want 1", solved_cnt); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ls_idle: got %b want 0", busy); end
  endtask

  task automatic test_empty();
    drive_line(0, -1, 0, 2, 1'b0, -1);
    checks++; if (timeout !== 0) begin errors++; $display("FAIL empty_timeout: got %0d want 0", timeout); end
    checks++; if (pulse_cnt !== 0) begin errors++; $display("FAIL empty_reads: got %0d want 0", pulse_cnt); end
    checks++; if (ever_rdy !== 1'b0) begin errors++; $display("FAIL empty_rdy: got %b want 0", ever_rdy); end
    checks++; if (solved_lat < 1 || solved_lat > 3) begin errors++; $display("FAIL empty_latency: got %0d want 1..3", solved_lat); end
    checks++; if (solved_cnt !== 1) begin errors++; $display("FAIL empty_solved: got %0d want 1", solved_cnt); end
  endtask

  task automatic test_long();
    logic [7:0] c, want, got;
    for (int i = 0; i < 200; i++) src[i] = 8'(i + 32);
    drive_line(200, -1, 0, 3, 1'b0, -1);
    checks++; if (timeout !== 0) begin errors++; $display("FAIL long_timeout: got %0d want 0", timeout); end
    checks++; if (pulse_cnt !== 128) begin errors++; $display("FAIL long_reads: got %0d want 128", pulse_cnt); end
    checks++; if (gap_bad !== 0) begin errors++; $display("FAIL long_gap: got %0d want 0", gap_bad); end
    checks++; if (echo_q.size() !== 129) begin errors++; $display("FAIL long_len: got %0d want 129", echo_q.size()); end
    for (int i = 0; i < 129; i++) begin
      c = 8'(i + 32);
      if (i == 128) want = 8'h00;
      else if (c >= 8'h61 && c <= 8'h7A) want = c - 8'h20;
      else want = c;
      got = (i < echo_q.size()) ? echo_q[i] : 8'hxx;
      checks++; if (got !== want) begin errors++; $display("FAIL long_char%0d: got %h want %h", i, got, want); end
    end
  endtask

  task automatic test_slow_ack();
    string want = "HELLO, W0RLD!{";
    logic [7:0] w, got;
    load_str("Hello, w0rld!{");
    src[14] = 8'h60;
    drive_line(15, -1, 10, 2, 1'b0, -1);
    checks++; if (timeout !== 0) begin errors++; $display("FAIL slow_timeout: got %0d want 0", timeout); end
    checks++; if (stable_bad !== 0) begin errors++; $display("FAIL slow_stable: got %0d changes want 0", stable_bad); end
    checks++; if (echo_q.size() !== 16) begin errors++; $display("FAIL slow_len: got %0d want 16", echo_q.size()); end
    for (int i = 0; i < 16; i++) begin
      if (i < 14) w = want[i];
      else if (i == 14) w = 8'h60;
      else w = 8'h00;
      got = (i < echo_q.size()) ? echo_q[i] : 8'hxx;
      checks++; if (got !== w) begin errors++; $display("FAIL slow_char%0d: got %h want %h", i, got, w); end
    end
  endtask

  task automatic test_early_drop();
    logic [7:0] want [4] = '{8'h41, 8'h42, 8'h43, 8'h00};
    logic [7:0] got;
    load_str("abcde");
    drive_line(5, 3, 0, 2, 1'b0, -1);
    checks++; if (timeout !== 0) begin errors++; $display("FAIL drop_timeout: got %0d want 0", timeout); end
    checks++; if (pulse_cnt !== 3) begin errors++; $display("FAIL drop_reads: got %0d want 3", pulse_cnt); end
    checks++; if (echo_q.size() !== 4) begin errors++; $display("FAIL drop_len: got %0d want 4", echo_q.size()); end
    for (int i = 0; i < 4; i++) begin
      got = (i < echo_q.size()) ? echo_q[i] : 8'hxx;
      checks++; if (got !== want[i]) begin errors++; $display("FAIL drop_char%0d: got %h want %h", i, got, want[i]); end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] got;
    load_str("xyzzy12");
    drive_line(7, -1, 0, 2, 1'b0, 3);
    got = (echo_q.size() > 2) ? echo_q[2] : 8'hxx;
    checks++; if (got !== 8'h5A) begin errors++; $display("FAIL mid_third: got %h want 5a", got); end
    #1 rst_n = 1'b0;
    #1;
    checks++; if (in_newASCII_ready !== 1'b0) begin errors++; $display("FAIL mid_rdy: got %b want 0", in_newASCII_ready); end
    checks++; if (lineIn !== 8'h00) begin errors++; $display("FAIL mid_linein: got %h want 00", lineIn); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy: got %b want 0", busy); end
    checks++; if (lineOut_nextASCII !== 1'b0 || in_solved !== 1'b0) begin errors++; $display("FAIL mid_pulses: got %b%b want 00", lineOut_nextASCII, in_solved); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++; if ({busy, in_newASCII_ready, lineOut_nextASCII, in_solved} !== 4'b0000) begin
        errors++; $display("FAIL mid_quiet%0d: got %b want 0000", i, {busy, in_newASCII_ready, lineOut_nextASCII, in_solved});
      end
    end
    load_str("ok");
    drive_line(2, -1, 0, 2, 1'b0, -1);
    checks++; if (echo_q.size() !== 3) begin errors++; $display("FAIL mid_next_len: got %0d want 3", echo_q.size()); end
    got = (echo_q.size() > 1) ? echo_q[1] : 8'hxx;
    checks++; if (got !== 8'h4B) begin errors++; $display("FAIL mid_next_char: got %h want 4b", got); end
  endtask

  task automatic test_waitack();
    logic [7:0] got;
    load_str("cd");
    drive_line(2, -1, 0, 50, 1'b1, -1);
    checks++; if (timeout !== 0) begin errors++; $display("FAIL wait_timeout: got %0d want 0", timeout); end
    checks++; if (busy_bad !== 0) begin errors++; $display("FAIL wait_busy: got %0d low cycles want 0", busy_bad); end
    checks++; if (solved_cnt !== 1) begin errors++; $display("FAIL wait_solved: got %0d want 1", solved_cnt); end
    checks++; if (pulse_cnt !== 2) begin errors++; $display("FAIL wait_reads: got %0d want 2", pulse_cnt); end
    got = (echo_q.size() > 1) ? echo_q[1] : 8'hxx;
    checks++; if (got !== 8'h44) begin errors++; $display("FAIL wait_char: got %h want 44", got); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL wait_idle: got %b want 0", busy); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] want [4] = '{8'h50, 8'h57, 8'h44, 8'h00};
    logic [7:0] got;
    load_str("pwd");
    drive_line(3, -1, 0, 2, 1'b0, -1);
    checks++; if (timeout !== 0) begin errors++; $display("FAIL b2b_timeout: got %0d want 0", timeout); end
    checks++; if (pulse_cnt !== 3) begin errors++; $display("FAIL b2b_reads: got %0d want 3", pulse_cnt); end
    for (int i = 0; i < 4; i++) begin
      got = (i < echo_q.size()) ? echo_q[i] : 8'hxx;
      checks++; if (got !== want[i]) begin errors++; $display("FAIL b2b_char%0d: got %h want %h", i, got, want[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_ls();
    test_empty();
    test_long();
    test_slow_ack();
    test_early_drop();
    test_reset_mid();
    test_waitack();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bash_line_echo.md
BASH_LINE_ECHO -- requirements
Module: bash_line_echo

Interface
REQ-001 Parameter BUFFER_LEN, default 128, SHALL set line storage depth in characters.
REQ-002 Parameter UPCASE, default 1, SHALL enable a-z to A-Z conversion on the echoed line when 1.
REQ-003 clk  input  1  system clock; all state SHALL change on posedge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 out_newASCII_ready  input  1  bash has a completed line available.
REQ-006 out_lineLen  input  13  line length in characters, valid while out_newASCII_ready=1.
REQ-007 lineOut  input  8  current line character; 0 once all characters are read.
REQ-008 lineOut_nextASCII  output  1  one-cycle pulse: character consumed, advance.
REQ-009 in_newASCII_ready  output  1  response character available on lineIn.
REQ-010 lineIn  output  8  response character; 0 terminates the line.
REQ-011 lineIn_nextASCII  input  1  bash consumed the current lineIn character.
REQ-012 in_solved  output  1  one-cycle pulse: command finished.
REQ-013 out_solved  input  1  bash acknowledged in_solved.
REQ-014 busy  output  1  high in every state except IDLE.

Function
REQ-015 The block SHALL implement the states IDLE, RECV, EMIT, SOLVE and WAITACK.
REQ-016 In IDLE, out_newASCII_ready=1 SHALL latch len=min(out_lineLen,BUFFER_LEN), clear rx_cnt, and go to RECV.
REQ-017 In RECV, in a cycle where the registered lineOut_nextASCII is 0 and rx_cnt<len, the block SHALL store lineOut at buf[rx_cnt], increment rx_cnt, and drive lineOut_nextASCII=1 for exactly one cycle.
REQ-018 RECV SHALL NOT sample lineOut in a cycle where lineOut_nextASCII=1, giving a throughput of 2 cycles per character.
REQ-019 RECV SHALL exit when rx_cnt==len, or when out_newASCII_ready falls early; on exit, len:=rx_cnt.
REQ-020 On RECV exit with len=0, the block SHALL go to SOLVE; otherwise it SHALL clear tx_idx and go to EMIT.
REQ-021 In EMIT, in_newASCII_ready SHALL be 1 and lineIn SHALL be conv(buf[tx_idx]) when tx_idx<len, else 0.
REQ-022 conv SHALL subtract 8'h20 from 8'h61..8'h7A when UPCASE=1 and SHALL pass all other values unchanged.
REQ-023 In EMIT, lineIn_nextASCII=1 with tx_idx<len SHALL increment tx_idx.
REQ-024 In EMIT, lineIn_nextASCII=1 with tx_idx==len (terminator consumed) SHALL clear in_newASCII_ready on the next edge and go to SOLVE.
REQ-025 lineIn and in_newASCII_ready SHALL be held stable between lineIn_nextASCII pulses.
REQ-026 A lineIn_nextASCII pulse of more than one cycle SHALL advance tx_idx once per cycle; bash guarantees single-cycle pulses.
REQ-027 SOLVE SHALL drive in_solved=1 for exactly one cycle and then go to WAITACK.
REQ-028 WAITACK SHALL go to IDLE on out_solved=1.
REQ-029 out_solved received in any state other than WAITACK SHALL be ignored.
REQ-030 out_newASCII_ready asserted in any state other than IDLE SHALL be ignored.
REQ-031 Characters beyond BUFFER_LEN SHALL NOT be read and SHALL NOT be stored.
REQ-032 rx_cnt, tx_idx and len SHALL be 13 bits wide and SHALL never exceed BUFFER_LEN.

Reset
REQ-033 While rst_n=0, state SHALL be IDLE and lineOut_nextASCII, in_newASCII_ready, lineIn, in_solved, busy, rx_cnt, tx_idx and len SHALL all be 0.
REQ-034 Reset asserted mid-RECV or mid-EMIT SHALL abort the transfer with no further pulses; buf contents are don't-care after reset.

Verification
REQ-035 Line "ls" (out_lineLen=2): exactly 2 lineOut_nextASCII pulses, 2 cycles apart -> lineIn sequence 8'h4C, 8'h53, 8'h00 -> one in_solved pulse.
REQ-036 Empty line (out_lineLen=0): zero lineOut_nextASCII pulses and in_newASCII_ready never 1 -> in_solved within 3 cycles of out_newASCII_ready.
REQ-037 out_lineLen=200: exactly 128 reads; 128 characters echoed plus the 0 terminator.
REQ-038 Bash delays lineIn_nextASCII by 10 cycles: lineIn stays constant; no character is skipped or duplicated.
REQ-039 rst_n pulsed low after 3 echoed characters: all outputs 0 immediately; the next line is processed normally from IDLE.
REQ-040 out_solved withheld for 50 cycles: busy=1 throughout, in_solved pulses once, and a new out_newASCII_ready is ignored until out_solved arrives.
